mtm_alu_serializer: RTL and testbench
=====================================

Name: mtm_alu_serializer

Overview:
Transmit end of the MTM ALU serial protocol. It takes one ALU result packet (32-bit C plus 4 flags) or one error packet (6 error bits) through a valid/ready handshake. It serializes the packet onto `sout` as back-to-back 11-bit frames, computing the CRC3 or parity on the way. It sits between the ALU core output register and the chip `sout` pad, and its output is what the ALU testbench `compare`/`compare_ctl` tasks sample.

Parameters:
- CLKS_PER_BIT, 1, clock cycles each serial bit is held on `sout` (≥1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  packet on `in_*` is valid.
- in_ready  output  1  block can accept a packet this cycle.
- in_is_err  input  1  1 = error packet, 0 = result packet.
- in_data  input  32  result C (ignored when `in_is_err`=1).
- in_flags  input  4  {carry, overflow, zero, negative} (ignored when `in_is_err`=1).
- in_err  input  6  {ERR_DATA, ERR_CRC, ERR_OP} bits (ignored when `in_is_err`=0).
- sout  output  1  serial line; idle high.
- busy  output  1  high while a packet is being shifted.

Behaviour:
- Reset (synchronous, `rst`=1 at a clk edge): `sout`=1, `in_ready`=1, `busy`=0, FSM=IDLE, all counters 0. Reset mid-packet aborts the packet immediately: `sout` is 1 from the next edge and no remaining bits are sent.
- Frame format: one frame is 11 bits: start 0, type bit, byte[7:0] MSB first, stop 1.
  - Data frames carry type 0.
  - The CTL frame carries type 1.
- Result packet: 5 frames, 55 bits, no gaps.
  - Data frames carry C[31:24], C[23:16], C[15:8], C[7:0], in that order.
  - CTL byte = {1'b0, flags[3:0], crc3[2:0]}.
  - crc3 is CRC over the 37-bit vector {C, 1'b0, flags}, polynomial x^3+x+1, init 0, MSB first. It is bit-identical to the team golden model crc3_37.
- Error packet: a single CTL frame, 11 bits.
  - CTL byte = {1'b1, err[5:0], par}, where par = ~^err, giving even parity over the 8-bit byte.
- Handshake:
  - `in_ready` = (FSM==IDLE) and not `rst`.
  - Transfer occurs when `in_valid` && `in_ready` at a rising edge. All `in_*` fields are captured into internal registers on that edge, so the source may change them afterwards.
  - When `in_valid` is low in IDLE, nothing happens.
- Latency: the start bit of the first frame appears on `sout` in the cycle after the accepting edge. There are no bubbles between frames.
- FSM, with bit_cnt (0..10), frame_cnt (0..4) and div_cnt (0..CLKS_PER_BIT-1):
  - IDLE: `sout`=1. On accept → SHIFT, with bit_cnt=0, div_cnt=0, frame_cnt=0; a result packet instead loads frame_cnt=0 and last=4, an error packet loads last=0 with the CTL byte selected.
  - SHIFT: `sout` = frame bit[bit_cnt]. div_cnt advances every cycle. On div_cnt wrap, bit_cnt increments. On bit_cnt 10→0, frame_cnt increments. After the stop bit of the last frame → IDLE.
  - DONE is implicit: IDLE is entered for at least one cycle with `sout`=1, so `in_ready` returns one cycle after the final stop bit ends.
- Timing: one result packet occupies exactly 55×CLKS_PER_BIT cycles; an error packet occupies 11×CLKS_PER_BIT cycles.
- `busy` = (FSM==SHIFT).
- `in_valid` asserted while busy is ignored, because `in_ready`=0; no buffering.
- The CRC is computed combinationally from the captured registers. Only the registered `sout` is output-visible.
- `sout` is driven from a flop, so there are no glitches.

Decomposition:
- Package mtm_alu_pkg holds:
  - opcode constants AND/OR/ADD/SUB;
  - ERR_DATA=6'b100100, ERR_CRC=6'b010010, ERR_OP=6'b001001;
  - TYPE_DATA=0, TYPE_CMD=1;
  - FRAME_BITS=11, RESULT_FRAMES=5;
  - the FSM state encoding.
- One natural sub-module: mtm_alu_crc3 (37-bit in, 3-bit out, combinational), shared with the receiver-side checker.

Test Plan:
- Reset then `in_valid` with result C=0x00000000, flags=4'b0010 → after 1 cycle `sout` emits 4×(0,0,00000000,1) then 0,1,00010110,1 (CTL byte 0x16, crc3=3'b110). `busy` is high for 55 cycles, `in_ready` is high again on cycle 57.
- Error packet `in_err`=ERR_DATA → `sout` = 0,1,1,100100,1,1 (11 bits); likewise ERR_CRC → 0,1,1,010010,1,1 and ERR_OP → 0,1,1,001001,1,1.
- 1000 random C/flags → the 55 captured bits equal the golden model frame {00,C[31:24],1,...,010,flags,crc3_37,1} for every packet.
- Hold `in_valid`=1 with new data during transmission → `in_ready`=0 throughout and the first packet is uncorrupted. The second packet starts exactly 1 idle cycle after the last stop bit.
- Assert `rst` on bit 20 of a result packet → `sout`=1, `busy`=0, `in_ready`=1 from the next cycle. A following packet transmits correctly.
- CLKS_PER_BIT=4, C=0xFFFFFFFF, flags=4'b0001 → each bit is held 4 cycles and the packet is 220 cycles long. Bit contents match the first scenario's rules.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: shared constants and types for the MTM ALU serial protocol.
//   - ALU opcode constants
//   - error-flag encodings carried in the error CTL frame
//   - frame type bits, frame geometry
//   - serializer FSM state encoding
//   - helpers: error-byte parity and per-bit frame selection
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam logic [5:0] ERR_DATA = 6'b100100;
  localparam logic [5:0] ERR_CRC  = 6'b010010;
  localparam logic [5:0] ERR_OP   = 6'b001001;

  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CMD  = 1'b1;

  localparam int unsigned FRAME_BITS    = 11;
  localparam int unsigned RESULT_FRAMES = 5;

  localparam logic [3:0] LAST_BIT          = 4'(FRAME_BITS - 1);
  localparam logic [2:0] LAST_RESULT_FRAME = 3'(RESULT_FRAMES - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // Parity bit that makes the error CTL byte {1, err, par} even.
  function automatic logic err_parity(input logic [5:0] err);
    return ~^err;
  endfunction

  // Bit idx of a frame {start 0, type, byte MSB first, stop 1}.
  function automatic logic frame_bit(input logic typ, input logic [7:0] byte_v,
                                     input logic [3:0] idx);
    logic [3:0] pos;
    logic       b;
    pos = 4'd9 - idx;
    case (idx)
      4'd0:    b = 1'b0;
      4'd1:    b = typ;
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
               b = byte_v[pos[2:0]];
      default: b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mtm_alu_crc3.sv
// mtm_alu_crc3: combinational CRC3 (x^3+x+1, init 0, MSB first) over the
// 37-bit vector {C, 1'b0, flags}. Shared with the receiver-side checker.
//   data_in [36:0] : message, bit 36 shifted in first
//   crc_out [2:0]  : remainder
module mtm_alu_crc3 (
  input  logic [36:0] data_in,
  output logic [2:0]  crc_out
);

  logic [2:0] crc_v;
  logic       fb_v;

  // Bit-serial LFSR unrolled over all 37 message bits.
  always_comb begin
    crc_v = 3'b000;
    fb_v  = 1'b0;
    for (int i = 36; i >= 0; i--) begin
      fb_v  = crc_v[2] ^ data_in[i];
      crc_v = {crc_v[1], crc_v[0] ^ fb_v, fb_v};
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: transmit end of the MTM ALU serial protocol.
// Accepts one result packet (C + flags) or one error packet through a
// valid/ready handshake and shifts it onto sout as 11-bit frames.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake
//   in_is_err           : 1 = error packet, 0 = result packet
//   in_data, in_flags   : result C and {carry, overflow, zero, negative}
//   in_err              : error bits
//   sout                : registered serial line, idle high
//   busy                : high while a packet is being shifted
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_err,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_flags,
  input  logic [5:0]  in_err,
  output logic        sout,
  output logic        busy
);

  localparam int unsigned    DIV_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  ser_state_e       state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       frame_cnt_q, frame_cnt_d;
  logic [2:0]       last_q, last_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             is_err_q, is_err_d;
  logic [31:0]      data_q, data_d;
  logic [3:0]       flags_q, flags_d;
  logic [5:0]       err_q, err_d;
  logic             sout_q, sout_d;

  logic [2:0]       crc_s;
  logic             cur_type;
  logic [7:0]       cur_byte;

  mtm_alu_crc3 u_crc (
    .data_in ({data_q, 1'b0, flags_q}),
    .crc_out (crc_s)
  );

  // State register: FSM, counters, captured packet and the sout flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      frame_cnt_q <= 3'd0;
      last_q      <= 3'd0;
      div_cnt_q   <= '0;
      is_err_q    <= 1'b0;
      data_q      <= 32'd0;
      flags_q     <= 4'd0;
      err_q       <= 6'd0;
      sout_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      last_q      <= last_d;
      div_cnt_q   <= div_cnt_d;
      is_err_q    <= is_err_d;
      data_q      <= data_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      sout_q      <= sout_d;
    end
  end

  // Next-state logic: capture on accept, then walk div/bit/frame counters.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    last_d      = last_q;
    div_cnt_d   = div_cnt_q;
    is_err_d    = is_err_q;
    data_d      = data_q;
    flags_d     = flags_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        // rst is handled by the register, so in_valid alone means accept here
        if (in_valid) begin
          state_d     = ST_SHIFT;
          bit_cnt_d   = 4'd0;
          frame_cnt_d = 3'd0;
          div_cnt_d   = '0;
          last_d      = in_is_err ? 3'd0 : LAST_RESULT_FRAME;
          is_err_d    = in_is_err;
          data_d      = in_data;
          flags_d     = in_flags;
          err_d       = in_err;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = 4'd0;
            if (frame_cnt_q == last_q) begin
              state_d     = ST_IDLE;
              frame_cnt_d = 3'd0;
            end else begin
              frame_cnt_d = frame_cnt_q + 3'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: choose the frame for the next cycle and its bit for sout_d.
  always_comb begin
    cur_type = TYPE_DATA;
    cur_byte = 8'd0;
    if (is_err_q) begin
      cur_type = TYPE_CMD;
      cur_byte = {1'b1, err_q, err_parity(err_q)};
    end else if (frame_cnt_d == LAST_RESULT_FRAME) begin
      cur_type = TYPE_CMD;
      cur_byte = {1'b0, flags_q, crc_s};
    end else begin
      cur_type = TYPE_DATA;
      case (frame_cnt_d)
        3'd0:    cur_byte = data_q[31:24];
        3'd1:    cur_byte = data_q[23:16];
        3'd2:    cur_byte = data_q[15:8];
        default: cur_byte = data_q[7:0];
      endcase
    end

    // On accept the first bit is always the start bit, so it does not depend
    // on the not-yet-captured packet registers.
    if (state_q == ST_IDLE) begin
      sout_d = in_valid ? 1'b0 : 1'b1;
    end else if (state_d == ST_SHIFT) begin
      sout_d = frame_bit(cur_type, cur_byte, bit_cnt_d);
    end else begin
      sout_d = 1'b1;
    end

    in_ready = (state_q == ST_IDLE) && !rst;
    busy     = (state_q == ST_SHIFT);
  end

  assign sout = sout_q;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
module tb_mtm_alu_serializer;

  typedef struct {
    logic [54:0] bits;   // first transmitted bit at index len-1
    int          len;
    bit          abort;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst_w = 2'b11;
  logic [1:0]  valid_w = 2'b00;
  logic [1:0]  in_ready_w, sout_w, busy_w;
  logic        in_is_err = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic [3:0]  in_flags = 4'd0;
  logic [5:0]  in_err = 6'd0;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  mtm_alu_serializer #(.CLKS_PER_BIT(1)) dut (
    .clk(clk), .rst(rst_w[0]), .in_valid(valid_w[0]), .in_ready(in_ready_w[0]),
    .in_is_err(in_is_err), .in_data(in_data), .in_flags(in_flags), .in_err(in_err),
    .sout(sout_w[0]), .busy(busy_w[0]));

  mtm_alu_serializer #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst_w[1]), .in_valid(valid_w[1]), .in_ready(in_ready_w[1]),
    .in_is_err(in_is_err), .in_data(in_data), .in_flags(in_flags), .in_err(in_err),
    .sout(sout_w[1]), .busy(busy_w[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // CRC as the remainder of polynomial long division of m(x)*x^3 by x^3+x+1.
  function automatic logic [2:0] crc_ref(input logic [36:0] m);
    logic [39:0] r;
    r = {m, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic logic [10:0] frm(input logic t, input logic [7:0] b);
    return {1'b0, t, b, 1'b1};
  endfunction

  function automatic exp_t make_exp(input logic is_err, input logic [31:0] c,
                                    input logic [3:0] f, input logic [5:0] e);
    exp_t x;
    logic par;
    x.abort = 1'b0;
    if (is_err) begin
      par    = ($countones({1'b1, e}) % 2 == 1) ? 1'b1 : 1'b0;
      x.bits = {44'd0, frm(1'b1, {1'b1, e, par})};
      x.len  = 11;
    end else begin
      x.bits = {frm(1'b0, c[31:24]), frm(1'b0, c[23:16]), frm(1'b0, c[15:8]),
                frm(1'b0, c[7:0]), frm(1'b1, {1'b0, f, crc_ref({c, 1'b0, f})})};
      x.len  = 55;
    end
    return x;
  endfunction

  task automatic push_exp(input int k, input exp_t x);
    if (k == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  task automatic send(input int k, input logic is_err, input logic [31:0] c,
                      input logic [3:0] f, input logic [5:0] e, input bit abort);
    exp_t x;
    int n;
    @(negedge clk);
    in_is_err = is_err; in_data = c; in_flags = f; in_err = e;
    valid_w[k] = 1'b1;
    n = 0;
    while (!in_ready_w[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_w[k]) begin
      check("accept_timeout", 64'(n), 64'd0);
      valid_w[k] = 1'b0;
    end else begin
      x = make_exp(is_err, c, f, e);
      x.abort = abort;
      push_exp(k, x);
      @(posedge clk);
      #1;
      valid_w[k] = 1'b0;
      in_is_err = 1'($urandom); in_data = $urandom; in_flags = 4'($urandom); in_err = 6'($urandom);
      @(negedge clk);
      check("start_latency", 64'({busy_w[k], sout_w[k]}), 64'(2'b10));
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (busy_w[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic monitor(input int k, input int cpb);
    exp_t x;
    logic [54:0] got, m;
    bit aborted, bad_ctl, empty;
    int nb, w;
    forever begin
      @(negedge clk);
      if (busy_w[k] && !rst_w[k]) begin
        empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
          check("unexpected_packet", 64'd1, 64'd0);
          w = 0;
          while (busy_w[k] && w < 400) begin
            @(negedge clk);
            w++;
          end
        end else begin
          x = (k == 0) ? q0.pop_front() : q1.pop_front();
          got = '0; aborted = 0; bad_ctl = 0; nb = 0;
          for (int i = 0; i < x.len && !aborted; i++) begin
            for (int c = 0; c < cpb && !aborted; c++) begin
              if (i != 0 || c != 0) @(negedge clk);
              if (rst_w[k]) begin
                aborted = 1;
              end else begin
                if (c == 0) got[x.len-1-i] = sout_w[k];
                else if (sout_w[k] !== got[x.len-1-i]) bad_ctl = 1;
                if (!busy_w[k] || in_ready_w[k]) bad_ctl = 1;
                nb = i + 1;
              end
            end
          end
          m = '0;
          for (int j = 0; j < nb; j++) m[x.len-1-j] = 1'b1;
          check("abort_seen", 64'(aborted), 64'(x.abort));
          check("packet_bits", 64'(got & m), 64'(x.bits & m));
          check("hold_busy_ready", 64'(bad_ctl), 64'd0);
          @(negedge clk);
          check("idle_after", 64'({busy_w[k], sout_w[k], in_ready_w[k]}), 64'(3'b011));
        end
      end
    end
  endtask

  initial begin
    exp_t xa, xb;
    int n;
    logic [31:0] c;
    logic [3:0] f;

    fork
      monitor(0, 1);
      monitor(1, 4);
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", 64'(in_ready_w), 64'(2'b00));
    @(posedge clk);
    #1;
    rst_w = 2'b00;
    @(negedge clk);
    check("reset_state0", 64'({busy_w[0], sout_w[0], in_ready_w[0]}), 64'(3'b011));
    check("reset_state1", 64'({busy_w[1], sout_w[1], in_ready_w[1]}), 64'(3'b011));

    // directed result and error packets
    send(0, 1'b0, 32'h0000_0000, 4'b0010, 6'd0, 1'b0);
    send(0, 1'b1, 32'd0, 4'd0, 6'b100100, 1'b0);
    send(0, 1'b1, 32'd0, 4'd0, 6'b010010, 1'b0);
    send(0, 1'b1, 32'd0, 4'd0, 6'b001001, 1'b0);
    send(0, 1'b0, 32'hFFFF_FFFF, 4'b1111, 6'd0, 1'b0);

    // valid held through a transmission: second packet after exactly one idle cycle
    wait_idle(0);
    @(negedge clk);
    c = $urandom; f = 4'($urandom);
    in_is_err = 1'b0; in_data = c; in_flags = f;
    valid_w[0] = 1'b1;
    xa = make_exp(1'b0, c, f, 6'd0);
    push_exp(0, xa);
    @(posedge clk);
    #1;
    c = $urandom; f = 4'($urandom);
    in_data = c; in_flags = f;
    xb = make_exp(1'b0, c, f, 6'd0);
    push_exp(0, xb);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready_w[0] && n < 200);
    check("b2b_gap", 64'(n), 64'd56);
    @(posedge clk);
    #1;
    valid_w[0] = 1'b0;
    wait_idle(0);

    // reset during bit 20 of a result packet, then a clean packet
    send(0, 1'b0, $urandom, 4'($urandom), 6'd0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    rst_w[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_w[0] = 1'b0;
    send(0, 1'b0, $urandom, 4'($urandom), 6'd0, 1'b0);

    // CLKS_PER_BIT = 4 instance
    send(1, 1'b0, 32'hFFFF_FFFF, 4'b0001, 6'd0, 1'b0);
    send(1, 1'b1, 32'd0, 4'd0, 6'b010010, 1'b0);
    send(1, 1'b0, $urandom, 4'($urandom), 6'd0, 1'b0);

    // random packets
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(0, 1'b0, $urandom, 4'($urandom), 6'($urandom), 1'b0);
    end
    for (int i = 0; i < 20; i++)
      send(0, 1'b1, $urandom, 4'($urandom), 6'($urandom), 1'b0);

    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);
    check("queue0_drained", 64'(q0.size()), 64'd0);
    check("queue1_drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
